// File: rtl/mem_io_ctrl.sv
// Memory-side responder for the cpu byte bus: 128KB RAM plus an I/O page at 0x30000 with
// RX/TX byte FIFOs, a free-running cycle counter with snapshot, and a sticky stop flag.
module mem_io_ctrl #(
  parameter int unsigned RAM_ADDR_W = 17,
  parameter int unsigned FIFO_LOG   = 4,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] a_in,
  input  logic        wr_in,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        prog_stop
);

  localparam int unsigned FifoDepth = 2 ** FIFO_LOG;

  logic [7:0] ram [2 ** RAM_ADDR_W];
  logic [7:0] rx_mem [FifoDepth];
  logic [7:0] tx_mem [FifoDepth];

  logic [FIFO_LOG-1:0] rx_wp, rx_rp, tx_wp, tx_rp;
  logic [FIFO_LOG:0]   rx_cnt, tx_cnt;
  logic [31:0]         counter, snapshot;
  logic [7:0]          rd_data;

  logic ram_sel, io_sel, io_data, io_tick;
  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rx_push, rx_pop, tx_push, tx_pop, rd_acc, ram_we;
  logic unused_a;

  assign unused_a = ^a_in[31:18];

  assign ram_sel = ~a_in[17];
  assign io_sel  = (a_in[17:16] == 2'b11);
  assign io_data = io_sel && (a_in[15:0] == 16'h0000);
  assign io_tick = io_sel && (a_in[15:2] == 14'h0001);

  assign rx_empty = (rx_cnt == '0);
  assign tx_empty = (tx_cnt == '0);
  assign rx_full  = rx_cnt[FIFO_LOG];
  assign tx_full  = tx_cnt[FIFO_LOG];

  // A write of 0x00 to the TX port is ignored, so it must never stall either.
  assign rdy_out = !(io_data && !wr_in && rx_empty) &&
                   !(io_data && wr_in && (din != 8'h00) && tx_full);

  assign rd_acc   = rdy_out && !wr_in;
  assign ram_we   = rdy_out && wr_in && ram_sel;
  assign rx_ready = ~rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = rd_acc && io_data;
  assign tx_push  = rdy_out && wr_in && io_data && (din != 8'h00);
  assign tx_valid = ~tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_data  = tx_valid ? tx_mem[tx_rp] : 8'h00;

  // Storage arrays carry no reset so RAM survives a reset.
  always_ff @(posedge clk_in) begin
    if (ram_we) ram[a_in[RAM_ADDR_W-1:0]] <= din;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
    if (tx_push) tx_mem[tx_wp] <= din;
  end

  always_comb begin
    rd_data = 8'h00;
    if (ram_sel) begin
      rd_data = ram[a_in[RAM_ADDR_W-1:0]];
    end else if (io_data) begin
      rd_data = rx_mem[rx_rp];
    end else if (io_tick) begin
      unique case (a_in[1:0])
        2'd0:    rd_data = counter[7:0];
        2'd1:    rd_data = snapshot[15:8];
        2'd2:    rd_data = snapshot[23:16];
        default: rd_data = snapshot[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      dout      <= 8'h00;
      counter   <= 32'h0;
      snapshot  <= 32'h0;
      prog_stop <= 1'b0;
      rx_wp     <= '0;
      rx_rp     <= '0;
      rx_cnt    <= '0;
      tx_wp     <= '0;
      tx_rp     <= '0;
      tx_cnt    <= '0;
    end else begin
      counter <= counter + 32'd1;
      if (rd_acc) dout <= rd_data;
      if (rd_acc && io_tick && (a_in[1:0] == 2'd0)) snapshot <= counter;
      if (rdy_out && wr_in && io_tick && (a_in[1:0] == 2'd0)) prog_stop <= 1'b1;

      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;

      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Scoreboard bench for mem_io_ctrl: the driver queues expected read bytes and TX bytes, and
// a negedge monitor pops and compares them whenever the DUT returns a read or hands off TX.
module tb_mem_io_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a = 32'h20000;
  logic        wr = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic        rdy_out;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready = 1'b0;
  logic        prog_stop;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  rd_q[$];
  logic [7:0]  tx_q[$];
  logic        chk_en = 1'b0;
  logic        pend = 1'b0;

  mem_io_ctrl dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .a_in     (a),
    .wr_in    (wr),
    .din      (din),
    .dout     (dout),
    .rdy_out  (rdy_out),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .prog_stop(prog_stop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: dout registered at the last edge is compared here; then note whether the
  // current cycle is an accepted checked read.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        if (rd_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL rd_extra: got %0h, expected no read", dout);
        end else begin
          e = rd_q.pop_front();
          check("rd_dout", {24'h0, dout}, {24'h0, e});
        end
      end
      pend = rdy_out && !wr && chk_en && !rst;
      if (tx_valid && tx_ready && !rst) begin
        if (tx_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL tx_extra: got %0h, expected no byte", tx_data);
        end else begin
          e = tx_q.pop_front();
          check("tx_data", {24'h0, tx_data}, {24'h0, e});
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Idle = write to the unmapped region: dropped, and dout holds.
  task automatic idle();
    a = 32'h20000;
    wr = 1'b1;
    din = 8'h00;
    chk_en = 1'b0;
  endtask

  task automatic wait_acc(input string name);
    int k = 0;
    @(negedge clk);
    while (!rdy_out && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rdy_out) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: got stall timeout, expected rdy_out=1", name);
    end
  endtask

  task automatic wr_op(input logic [31:0] addr, input logic [7:0] data);
    a = addr;
    wr = 1'b1;
    din = data;
    chk_en = 1'b0;
    wait_acc("wr_accept");
    cyc();
    idle();
  endtask

  task automatic rd_op(input logic [31:0] addr, input logic [7:0] exp);
    a = addr;
    wr = 1'b0;
    chk_en = 1'b1;
    rd_q.push_back(exp);
    wait_acc("rd_accept");
    cyc();
    idle();
  endtask

  initial begin
    idle();
    repeat (2) cyc();
    check("rst_dout", {24'h0, dout}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_prog_stop", {31'h0, prog_stop}, 32'h0);
    rst = 1'b0;
    cyc();

    // RAM write then read-after-write
    wr_op(32'h00123, 8'hA5);
    rd_op(32'h00123, 8'hA5);

    // RX: stall on empty, push arrives, read completes next cycle
    a = 32'h30000;
    wr = 1'b0;
    chk_en = 1'b1;
    rd_q.push_back(8'h41);
    @(negedge clk);
    check("rx_stall_empty", {31'h0, rdy_out}, 32'h0);
    cyc();
    rx_valid = 1'b1;
    rx_data = 8'h41;
    @(negedge clk);
    check("rx_stall_same_cycle", {31'h0, rdy_out}, 32'h0);
    cyc();
    rx_valid = 1'b0;
    @(negedge clk);
    check("rx_released", {31'h0, rdy_out}, 32'h1);
    cyc();
    idle();
    a = 32'h30000;
    wr = 1'b0;
    @(negedge clk);
    check("rx_empty_again", {31'h0, rdy_out}, 32'h0);
    cyc();
    idle();

    // TX: fill, stall on full, single pop releases, zero write ignored
    tx_ready = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tx_q.push_back(8'(i));
      wr_op(32'h30000, 8'(i));
    end
    @(negedge clk);
    check("tx_valid_full", {31'h0, tx_valid}, 32'h1);
    check("tx_head", {24'h0, tx_data}, 32'h1);
    cyc();
    a = 32'h30000;
    wr = 1'b1;
    din = 8'h77;
    tx_q.push_back(8'h77);
    @(negedge clk);
    check("tx_full_stall", {31'h0, rdy_out}, 32'h0);
    repeat (3) cyc();
    @(negedge clk);
    check("tx_full_stall_held", {31'h0, rdy_out}, 32'h0);
    cyc();
    tx_ready = 1'b1;
    @(negedge clk);
    check("tx_stall_during_pop", {31'h0, rdy_out}, 32'h0);
    cyc();
    tx_ready = 1'b0;
    @(negedge clk);
    check("tx_released", {31'h0, rdy_out}, 32'h1);
    cyc();
    idle();
    a = 32'h30000;
    wr = 1'b1;
    din = 8'h00;
    @(negedge clk);
    check("tx_zero_no_stall", {31'h0, rdy_out}, 32'h1);
    cyc();
    idle();
    tx_ready = 1'b1;
    repeat (20) cyc();
    tx_ready = 1'b0;
    check("tx_drained", {31'h0, tx_valid}, 32'h0);
    check("tx_q_empty", tx_q.size(), 32'h0);

    // Counter snapshot: counter is 0 in the release cycle, 300 after 300 edges
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (300) cyc();
    rd_op(32'h30004, 8'h2C);
    repeat (300) cyc();
    rd_op(32'h30005, 8'h01);
    rd_op(32'h30006, 8'h00);
    rd_op(32'h30007, 8'h00);

    // Stop flag and async reset
    wr_op(32'h30004, 8'h55);
    @(negedge clk);
    check("prog_stop_set", {31'h0, prog_stop}, 32'h1);
    repeat (5) cyc();
    check("prog_stop_sticky", {31'h0, prog_stop}, 32'h1);
    rx_valid = 1'b1;
    rx_data = 8'h5A;
    cyc();
    rx_valid = 1'b0;
    wr_op(32'h30000, 8'h66);
    rd_op(32'h00123, 8'hA5);
    cyc();
    check("tx_valid_pre_rst", {31'h0, tx_valid}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("arst_prog_stop", {31'h0, prog_stop}, 32'h0);
    check("arst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("arst_tx_data", {24'h0, tx_data}, 32'h0);
    check("arst_dout", {24'h0, dout}, 32'h0);
    check("arst_rx_ready", {31'h0, rx_ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    a = 32'h30000;
    wr = 1'b0;
    @(negedge clk);
    check("arst_rx_empty", {31'h0, rdy_out}, 32'h0);
    cyc();
    idle();
    rd_op(32'h00123, 8'hA5);

    // Unmapped region and other I/O addresses
    rd_op(32'h2ABCD, 8'h00);
    wr_op(32'h0ABCD, 8'h3C);
    wr_op(32'h2ABCD, 8'h99);
    rd_op(32'h0ABCD, 8'h3C);
    repeat (4) cyc();
    check("dout_hold", {24'h0, dout}, 32'h3C);
    rd_op(32'h30010, 8'h00);

    repeat (3) cyc();
    check("rd_q_empty", rd_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
